multi_digit_counter: RTL and testbench
======================================

# multi_digit_counter

Parametrised multi-digit up/down counter with built-in prescaler and multiplexed 7-segment drive. It is the next-generation counter/display block for the 1 kHz TinyTapeout-style designs. It replaces a single fixed decimal digit with DIGITS cascaded digits of configurable base, direction control, clear, optional saturation, and a time-multiplexed segment/digit-select output for driving a common display bus.

## Interface
- TICK_COUNT, default 1000: clk cycles per count step; legal range ≥1.
- DIGITS, default 2: number of cascaded digits; legal range 1..8.
- DIGIT_BASE, default 10: modulus of every digit; legal range 2..16.
- SCAN_COUNT, default 4: clk cycles each digit is displayed; legal range ≥1.
- SATURATE, default 0: 0 = wrap at limits; 1 = hold at limits.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  1 = prescaler and count run; 0 = both frozen. Scan is unaffected.
- dir  in  1  0 = count up; 1 = count down.
- clear  in  1  synchronous clear of count and prescaler.
- count  out  4*DIGITS  digit values; digit i is at [4i+3:4i], digit 0 is the least significant.
- segments  out  7  active-high segments of the selected digit; bit0 = a … bit6 = g.
- digit_sel  out  DIGITS  one-hot select of the displayed digit.
- wrap  out  1  one-cycle pulse when the count crosses a limit and wraps.

## Operation
- Priority, per clk edge: reset > clear > tick > hold.
- **Prescaler**
  - Width is clog2(TICK_COUNT), minimum 1 bit.
  - When enable=1 it counts 0..TICK_COUNT-1, then returns to 0.
  - tick is an internal combinational signal: enable=1 and prescaler==TICK_COUNT-1.
  - TICK_COUNT=1 gives a tick on every enabled cycle.
- **Count on tick, up (dir=0)**
  - Digit 0 increments.
  - A digit at DIGIT_BASE-1 goes to 0 and carries into the next digit.
- **Count on tick, down (dir=1)**
  - Digit 0 decrements.
  - A digit at 0 goes to DIGIT_BASE-1 and borrows from the next digit.
- **Limits**
  - Upper limit is all digits = DIGIT_BASE-1; lower limit is all digits = 0.
  - Up from the upper limit:
    - SATURATE=0: count becomes all-zero and wrap pulses.
    - SATURATE=1: count is unchanged and wrap stays 0.
  - Down from the lower limit:
    - SATURATE=0: count becomes all DIGIT_BASE-1 and wrap pulses.
    - SATURATE=1: count is unchanged and wrap stays 0.
- **dir timing:** dir is sampled only on the tick cycle. Changing dir between ticks has no other effect.
- **clear:** count ← 0, prescaler ← 0, wrap ← 0. It overrides a coincident tick and is effective regardless of enable.
- **Scan**
  - A scan counter runs 0..SCAN_COUNT-1 continuously, independent of enable and clear.
  - At terminal value, the digit index advances 0→1→…→DIGITS-1→0.
  - digit_sel and segments are registered from the current index and the current count.
- **Decode**, segments g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - A=1110111, B=1111100, C=0111001, D=1011110, E=1111001, F=1110001.
- Digit values never reach ≥ DIGIT_BASE.

## Timing
- **Reset values:** count=0, prescaler=0, scan counter=0, digit index=0, digit_sel=1 (one-hot bit 0), segments=0111111, wrap=0.
- **First step:** with enable=1 from the first edge after reset release, count changes on the TICK_COUNT-th edge. Steps repeat every TICK_COUNT enabled cycles.
- **Pausing:** deasserting enable freezes the prescaler phase. Re-enabling resumes with no lost or extra cycles.
- **wrap:** registered; high for exactly the cycle in which the wrapped count value is first visible on count.
- **count:** registered, zero latency from the tick edge.
- **segments / digit_sel latency:** one cycle behind count and the digit index. The update after a count change is visible one edge later.
- **Scan dwell:** each digit is selected for SCAN_COUNT cycles, giving a full scan period of DIGITS*SCAN_COUNT cycles.
- **Reset mid-count or mid-scan:** all state returns to reset values on that edge. No partial wrap pulse is emitted.

## Test plan
Parameters unless stated: TICK_COUNT=4, DIGITS=2, DIGIT_BASE=10, SCAN_COUNT=2, SATURATE=0.
- **Reset and up-count:** reset 1 cycle, then enable=1, dir=0 for 40 cycles → count=0x01 at edge 4, 0x09 at edge 36, 0x10 at edge 40; segments/digit_sel match the decode one cycle later.
- **Wrap up/down:**
  - Count to 0x99, one more tick → count=0x00 and a single-cycle wrap pulse.
  - dir=1 at 0x00, one tick → count=0x99 and wrap pulses.
- **Saturate:** with SATURATE=1, at 0x99 dir=0 for 3 ticks → count stays 0x99, wrap never 1; at 0x00 dir=1 → count stays 0x00.
- **Enable/clear:**
  - Drop enable for 10 cycles at prescaler=2 → count frozen; the next step arrives 2 enabled cycles after re-enable.
  - clear coincident with a tick at count 0x37 → count=0x00, wrap=0.
- **Scan and hex:** DIGIT_BASE=16, count=0xA5:
  - digit_sel sequence 01,01,10,10,… every 2 cycles.
  - segments 1101101 when digit_sel=01; 1110111 when digit_sel=10.
- **Reset mid-operation:** reset asserted at count 0x42 with scan index 1 → next edge count=0, digit_sel=01, segments=0111111, wrap=0.

Source files
------------

// File: rtl/multi_digit_counter_if.sv
// Bus bundle for multi_digit_counter: the control inputs (enable, dir, clear)
// and the count/display outputs. The master side drives the controls and the
// slave side is the counter.
interface multi_digit_counter_if #(
  parameter int DIGITS = 2
);
  logic                  enable;
  logic                  dir;
  logic                  clear;
  logic [4*DIGITS-1:0]   count;
  logic [6:0]            segments;
  logic [DIGITS-1:0]     digit_sel;
  logic                  wrap;

  modport master (
    output enable, dir, clear,
    input  count, segments, digit_sel, wrap
  );

  modport slave (
    input  enable, dir, clear,
    output count, segments, digit_sel, wrap
  );
endinterface

// File: rtl/multi_digit_counter.sv
// Multi-digit up/down counter with a built-in prescaler, optional saturation
// at the limits, and a time-multiplexed 7-segment drive (one digit at a time).
module multi_digit_counter #(
  parameter int TICK_COUNT = 1000,
  parameter int DIGITS     = 2,
  parameter int DIGIT_BASE = 10,
  parameter int SCAN_COUNT = 4,
  parameter int SATURATE   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_digit_counter_if.slave   bus
);

  localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = 4 * DIGITS;

  localparam logic [PW-1:0]     PRE_LAST  = PW'(TICK_COUNT - 1);
  localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_COUNT - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [3:0]        DIG_MAX   = 4'(DIGIT_BASE - 1);
  localparam logic [DIGITS-1:0] SEL_ONE   = DIGITS'(1);

  // Hex digit to active-high segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      4'hF:    s = 7'b1110001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]     pre_q, pre_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;

  logic              tick_s;
  logic [CW-1:0]     inc_s, dec_s;
  logic              at_max_s, at_min_s;

  assign tick_s = bus.enable && (pre_q == PRE_LAST);

  // Ripple increment/decrement across digits; also flags the two limits.
  // At a limit the ripple already yields the wrapped value.
  always_comb begin : step_calc
    logic       carry;
    logic       borrow;
    logic [3:0] dig;
    inc_s    = count_q;
    dec_s    = count_q;
    at_max_s = 1'b1;
    at_min_s = 1'b1;
    carry    = 1'b1;
    borrow   = 1'b1;
    dig      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig      = count_q[4*i +: 4];
      at_max_s = at_max_s && (dig == DIG_MAX);
      at_min_s = at_min_s && (dig == 4'd0);
      inc_s[4*i +: 4] = carry  ? ((dig == DIG_MAX) ? 4'd0 : dig + 4'd1) : dig;
      dec_s[4*i +: 4] = borrow ? ((dig == 4'd0) ? DIG_MAX : dig - 4'd1) : dig;
      carry  = carry  && (dig == DIG_MAX);
      borrow = borrow && (dig == 4'd0);
    end
  end

  // Prescaler phase: cleared by clear, advances only while enabled.
  always_comb begin
    pre_d = pre_q;
    if (bus.clear) begin
      pre_d = {PW{1'b0}};
    end else if (tick_s) begin
      pre_d = {PW{1'b0}};
    end else if (bus.enable) begin
      pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      pre_d = pre_q;
    end
  end

  // Count update on tick with direction, limit handling and the wrap pulse.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = {CW{1'b0}};
    end else if (tick_s) begin
      if (!bus.dir) begin
        count_d = (at_max_s && (SATURATE != 0)) ? count_q : inc_s;
        wrap_d  = at_max_s && (SATURATE == 0);
      end else begin
        count_d = (at_min_s && (SATURATE != 0)) ? count_q : dec_s;
        wrap_d  = at_min_s && (SATURATE == 0);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Free-running scan dwell counter and displayed digit index.
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = {SW{1'b0}};
      idx_d  = (idx_q == IDX_LAST) ? {IW{1'b0}} : idx_q + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      scan_d = scan_q + {{(SW-1){1'b0}}, 1'b1};
      idx_d  = idx_q;
    end
  end

  // Display drive from the current index and the current count.
  always_comb begin
    sel_d = SEL_ONE << idx_q;
    seg_d = seg_decode(count_q[4*idx_q +: 4]);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      wrap_q  <= 1'b0;
      scan_q  <= {SW{1'b0}};
      idx_q   <= {IW{1'b0}};
      sel_q   <= SEL_ONE;
      seg_q   <= 7'b0111111;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.digit_sel = sel_q;
  assign bus.segments  = seg_q;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Bench for multi_digit_counter: three instances (decimal wrap, decimal
// saturate, hex wrap) share one stimulus stream and are compared against a
// value-level reference model (count kept as an integer in base B).
module tb_multi_digit_counter;
  localparam int T = 4;
  localparam int D = 2;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multi_digit_counter_if #(.DIGITS(D)) if0 ();
  multi_digit_counter_if #(.DIGITS(D)) if1 ();
  multi_digit_counter_if #(.DIGITS(D)) if2 ();

  multi_digit_counter #(.TICK_COUNT(T), .DIGITS(D), .DIGIT_BASE(10), .SCAN_COUNT(S), .SATURATE(0))
    u_dut0 (.clk(clk), .reset(rst), .bus(if0));
  multi_digit_counter #(.TICK_COUNT(T), .DIGITS(D), .DIGIT_BASE(10), .SCAN_COUNT(S), .SATURATE(1))
    u_dut1 (.clk(clk), .reset(rst), .bus(if1));
  multi_digit_counter #(.TICK_COUNT(T), .DIGITS(D), .DIGIT_BASE(16), .SCAN_COUNT(S), .SATURATE(0))
    u_dut2 (.clk(clk), .reset(rst), .bus(if2));

  always #5 clk = ~clk;

  // Reference model state
  int         base_m [3] = '{10, 10, 16};
  int         sat_m  [3] = '{0, 1, 0};
  longint     val_m  [3];
  logic       wrap_m [3];
  logic [6:0] seg_m  [3];
  logic [D-1:0] sel_m [3];
  int         en_cycles;
  int         cyc;
  logic [6:0] enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic       dir_hold = 1'b0;

  function automatic logic [3:0] digit_of(input longint v, input int b, input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * b;
    return 4'((v / p) % b);
  endfunction

  function automatic logic [4*D-1:0] pack(input longint v, input int b);
    logic [4*D-1:0] r = '0;
    for (int d = 0; d < D; d++) r[4*d +: 4] = digit_of(v, b, d);
    return r;
  endfunction

  function automatic longint vmax(input int b);
    longint m = 1;
    for (int d = 0; d < D; d++) m = m * b;
    return m - 1;
  endfunction

  function automatic logic [4*D-1:0] dut_count(input int k);
    case (k)
      0: return if0.count;
      1: return if1.count;
      default: return if2.count;
    endcase
  endfunction

  function automatic logic [6:0] dut_seg(input int k);
    case (k)
      0: return if0.segments;
      1: return if1.segments;
      default: return if2.segments;
    endcase
  endfunction

  function automatic logic [D-1:0] dut_sel(input int k);
    case (k)
      0: return if0.digit_sel;
      1: return if1.digit_sel;
      default: return if2.digit_sel;
    endcase
  endfunction

  function automatic logic dut_wrap(input int k);
    case (k)
      0: return if0.wrap;
      1: return if1.wrap;
      default: return if2.wrap;
    endcase
  endfunction

  // Apply inputs, clock one edge, advance the model, settle.
  task automatic step(input logic r, input logic e, input logic di, input logic c);
    int idx;
    logic tick;
    logic [D-1:0] one = 1;
    rst = r;
    if0.enable = e; if0.dir = di; if0.clear = c;
    if1.enable = e; if1.dir = di; if1.clear = c;
    if2.enable = e; if2.dir = di; if2.clear = c;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        val_m[k] = 0; wrap_m[k] = 1'b0; sel_m[k] = one; seg_m[k] = enc[0];
      end
      en_cycles = 0;
      cyc = 0;
    end else begin
      idx  = (cyc / S) % D;
      tick = e && ((en_cycles % T) == T - 1);
      for (int k = 0; k < 3; k++) begin
        sel_m[k]  = one << idx;
        seg_m[k]  = enc[digit_of(val_m[k], base_m[k], idx)];
        wrap_m[k] = 1'b0;
        if (c) val_m[k] = 0;
        else if (tick) begin
          if (!di) begin
            if (val_m[k] == vmax(base_m[k])) begin
              if (sat_m[k] == 0) begin val_m[k] = 0; wrap_m[k] = 1'b1; end
            end else val_m[k] = val_m[k] + 1;
          end else begin
            if (val_m[k] == 0) begin
              if (sat_m[k] == 0) begin val_m[k] = vmax(base_m[k]); wrap_m[k] = 1'b1; end
            end else val_m[k] = val_m[k] - 1;
          end
        end
      end
      if (c) en_cycles = 0;
      else if (e) en_cycles++;
      cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_count(k) !== 8'h00) begin errors++; $display("FAIL reset_count dut%0d: got %h want 00", k, dut_count(k)); end
      checks++;
      if (dut_seg(k) !== 7'b0111111) begin errors++; $display("FAIL reset_seg dut%0d: got %b want 0111111", k, dut_seg(k)); end
      checks++;
      if (dut_sel(k) !== 2'b01) begin errors++; $display("FAIL reset_sel dut%0d: got %b want 01", k, dut_sel(k)); end
      checks++;
      if (dut_wrap(k) !== 1'b0) begin errors++; $display("FAIL reset_wrap dut%0d: got %b want 0", k, dut_wrap(k)); end
    end
  endtask

  task automatic test_up_count();
    logic [7:0] want;
    for (int n = 1; n <= 40; n++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_count(k) !== pack(val_m[k], base_m[k]) || dut_seg(k) !== seg_m[k] ||
            dut_sel(k) !== sel_m[k] || dut_wrap(k) !== wrap_m[k]) begin
          errors++;
          $display("FAIL up_count dut%0d edge %0d: got c=%h s=%b d=%b w=%b want c=%h s=%b d=%b w=%b",
                   k, n, dut_count(k), dut_seg(k), dut_sel(k), dut_wrap(k),
                   pack(val_m[k], base_m[k]), seg_m[k], sel_m[k], wrap_m[k]);
        end
      end
      if (n == 3 || n == 4 || n == 36 || n == 40) begin
        want = (n == 3) ? 8'h00 : (n == 4) ? 8'h01 : (n == 36) ? 8'h09 : 8'h10;
        checks++;
        if (if0.count !== want) begin errors++; $display("FAIL up_edge%0d: got %h want %h", n, if0.count, want); end
      end
    end
  endtask

  task automatic test_wrap();
    int guard = 0;
    while (val_m[0] != 99 && guard < 2000) begin step(1'b0, 1'b1, 1'b0, 1'b0); guard++; end
    checks++;
    if (guard >= 2000) begin errors++; $display("FAIL wrap_reach99: timeout"); end
    for (int n = 1; n <= 5; n++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (if0.count !== ((n < 4) ? 8'h99 : 8'h00)) begin errors++; $display("FAIL wrap_up_count n%0d: got %h", n, if0.count); end
      checks++;
      if (if0.wrap !== (n == 4)) begin errors++; $display("FAIL wrap_up_pulse n%0d: got %b want %b", n, if0.wrap, (n == 4)); end
      checks++;
      if (if1.count !== 8'h99 || if1.wrap !== 1'b0) begin
        errors++; $display("FAIL sat_hold_up n%0d: got %h/%b want 99/0", n, if1.count, if1.wrap);
      end
    end
    // Now one enabled cycle into the phase; three more reach the next tick.
    for (int n = 1; n <= 3; n++) step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (if0.count !== 8'h99 || if0.wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_down: got %h/%b want 99/1", if0.count, if0.wrap);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (if0.wrap !== 1'b0) begin errors++; $display("FAIL wrap_down_single: got %b want 0", if0.wrap); end
  endtask

  task automatic test_saturate();
    int guard = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n <= 4; n++) step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (if1.count !== 8'h00 || if1.wrap !== 1'b0) begin
      errors++; $display("FAIL sat_hold_down: got %h/%b want 00/0", if1.count, if1.wrap);
    end
    checks++;
    if (if0.count !== 8'h99) begin errors++; $display("FAIL wrap_from_zero: got %h want 99", if0.count); end
    while (val_m[1] != 99 && guard < 2000) begin step(1'b0, 1'b1, 1'b0, 1'b0); guard++; end
    checks++;
    if (guard >= 2000) begin errors++; $display("FAIL sat_reach99: timeout"); end
    for (int n = 1; n <= 3 * T; n++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (if1.count !== 8'h99 || if1.wrap !== 1'b0) begin
        errors++; $display("FAIL sat_hold_99 n%0d: got %h/%b want 99/0", n, if1.count, if1.wrap);
      end
    end
  endtask

  task automatic test_enable_clear();
    int guard = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (if0.count !== 8'h00) begin errors++; $display("FAIL en_frozen n%0d: got %h want 00", n, if0.count); end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (if0.count !== 8'h00) begin errors++; $display("FAIL en_resume1: got %h want 00", if0.count); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (if0.count !== 8'h01) begin errors++; $display("FAIL en_resume2: got %h want 01", if0.count); end
    while (!(val_m[0] == 37 && (en_cycles % T) == T - 1) && guard < 2000) begin
      step(1'b0, 1'b1, 1'b0, 1'b0); guard++;
    end
    checks++;
    if (guard >= 2000) begin errors++; $display("FAIL clr_reach37: timeout"); end
    checks++;
    if (if0.count !== 8'h37) begin errors++; $display("FAIL clr_pre: got %h want 37", if0.count); end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (if0.count !== 8'h00 || if0.wrap !== 1'b0) begin
      errors++; $display("FAIL clr_tick: got %h/%b want 00/0", if0.count, if0.wrap);
    end
  endtask

  task automatic test_scan_hex();
    int guard = 0;
    logic [6:0] want_seg;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    while (val_m[2] != 165 && guard < 2000) begin step(1'b0, 1'b1, 1'b0, 1'b0); guard++; end
    checks++;
    if (guard >= 2000) begin errors++; $display("FAIL hex_reachA5: timeout"); end
    checks++;
    if (if2.count !== 8'hA5) begin errors++; $display("FAIL hex_count: got %h want A5", if2.count); end
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (if2.digit_sel !== sel_m[2]) begin
        errors++; $display("FAIL scan_sel n%0d: got %b want %b", n, if2.digit_sel, sel_m[2]);
      end
      want_seg = (sel_m[2] == 2'b01) ? 7'b1101101 : 7'b1110111;
      checks++;
      if (if2.segments !== want_seg) begin
        errors++; $display("FAIL scan_seg n%0d: got %b want %b", n, if2.segments, want_seg);
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    while (!(val_m[0] == 42 && ((cyc / S) % D) == 1) && guard < 2000) begin
      step(1'b0, 1'b1, 1'b0, 1'b0); guard++;
    end
    checks++;
    if (guard >= 2000) begin errors++; $display("FAIL mid_reach42: timeout"); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (if0.count !== 8'h00 || if0.digit_sel !== 2'b01 || if0.segments !== 7'b0111111 || if0.wrap !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got c=%h d=%b s=%b w=%b want 00/01/0111111/0",
               if0.count, if0.digit_sel, if0.segments, if0.wrap);
    end
  endtask

  task automatic test_random();
    logic r, e, c;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(499) == 0);
      e = ($urandom_range(7) != 0);
      c = ($urandom_range(127) == 0);
      if ($urandom_range(15) == 0) dir_hold = ~dir_hold;
      step(r, e, dir_hold ^ ($urandom_range(31) == 0), c);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_count(k) !== pack(val_m[k], base_m[k]) || dut_seg(k) !== seg_m[k] ||
            dut_sel(k) !== sel_m[k] || dut_wrap(k) !== wrap_m[k]) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d: got c=%h s=%b d=%b w=%b want c=%h s=%b d=%b w=%b",
                   k, n, dut_count(k), dut_seg(k), dut_sel(k), dut_wrap(k),
                   pack(val_m[k], base_m[k]), seg_m[k], sel_m[k], wrap_m[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_saturate();
    test_enable_clear();
    test_scan_hex();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
